// File: rtl/serial_tx_0101.sv
// serial_tx_0101: parallel-load, MSB-first serial transmitter with a
// programmable idle gap after each word. It also keeps a reference count of
// overlapping "0101" patterns driven on x, for comparison against a detector.
module serial_tx_0101 #(
   parameter int   WIDTH    = 8,
   parameter int   GAP      = 1,
   parameter logic IDLE_BIT = 1'b0,
   parameter int   CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             x,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pattern_cnt
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [BW-1:0] BIT_INIT = BW'(WIDTH - 1);
   localparam logic [3:0]    GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam logic          GAP_ZERO = (GAP == 0);

   logic [1:0]       state;
   logic [WIDTH-1:0] sreg;
   logic [BW-1:0]    bitcnt;
   logic [3:0]       gapcnt;
   logic [2:0]       hist;
   logic             last_bit;
   logic             accept;

   // Final data bit of the current word is on x this cycle.
   assign last_bit = (state == S_SHIFT) && (bitcnt == '0);
   // With no gap, the next word may be taken on the last bit so words abut.
   assign ready    = (state == S_IDLE) || (last_bit && GAP_ZERO);
   assign accept   = load && ready;

   // Control FSM: state, bit/gap counters and the registered line outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         x      <= IDLE_BIT;
         busy   <= 1'b0;
         done   <= 1'b0;
         bitcnt <= '0;
         gapcnt <= '0;
      end else begin
         done <= last_bit;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state  <= S_SHIFT;
                  x      <= data_in[WIDTH-1];
                  busy   <= 1'b1;
                  bitcnt <= BIT_INIT;
               end
            end
            S_SHIFT: begin
               if (bitcnt != '0) begin
                  x      <= sreg[WIDTH-1];
                  bitcnt <= bitcnt - BW'(1);
               end else if (accept) begin
                  // Only reachable with no gap: start the next word seamlessly.
                  x      <= data_in[WIDTH-1];
                  bitcnt <= BIT_INIT;
               end else if (GAP_ZERO) begin
                  state <= S_IDLE;
                  x     <= IDLE_BIT;
                  busy  <= 1'b0;
               end else begin
                  state  <= S_GAP;
                  gapcnt <= GAP_INIT;
                  x      <= IDLE_BIT;
                  busy   <= 1'b0;
               end
            end
            S_GAP: begin
               if (gapcnt == 4'd0) begin
                  state <= S_IDLE;
               end else begin
                  gapcnt <= gapcnt - 4'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               x     <= IDLE_BIT;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Shift register holds the bits still to be sent, next bit in the MSB.
   always_ff @(posedge clk) begin
      if (accept) begin
         sreg <= {data_in[WIDTH-2:0], 1'b0};
      end else if (state == S_SHIFT) begin
         sreg <= {sreg[WIDTH-2:0], 1'b0};
      end
   end

   // Pattern tracker: counts overlapping "0101" on x, idle and gap bits included.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist        <= 3'b000;
         pattern_cnt <= '0;
      end else begin
         if ({hist, x} == 4'b0101) begin
            pattern_cnt <= pattern_cnt + CNT_W'(1);
         end
         hist <= {hist[1:0], x};
      end
   end

endmodule

// File: tb/tb_serial_tx_0101.sv
// Directed bench for serial_tx_0101: three instances share the stimulus
// (GAP=1, GAP=0, and GAP=1 with a 2-bit pattern counter).
module tb_serial_tx_0101;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       load = 1'b0;

   logic       ready0, x0, busy0, done0;
   logic [7:0] cnt0;
   logic       ready1, x1, busy1, done1;
   logic [7:0] cnt1;
   logic       ready2, x2, busy2, done2;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   serial_tx_0101 #(.WIDTH(8), .GAP(1), .IDLE_BIT(1'b0), .CNT_W(8)) u0 (
      .clk(clk), .reset(reset), .data_in(data_in), .load(load),
      .ready(ready0), .x(x0), .busy(busy0), .done(done0), .pattern_cnt(cnt0));

   serial_tx_0101 #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0), .CNT_W(8)) u1 (
      .clk(clk), .reset(reset), .data_in(data_in), .load(load),
      .ready(ready1), .x(x1), .busy(busy1), .done(done1), .pattern_cnt(cnt1));

   serial_tx_0101 #(.WIDTH(8), .GAP(1), .IDLE_BIT(1'b0), .CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .data_in(data_in), .load(load),
      .ready(ready2), .x(x2), .busy(busy2), .done(done2), .pattern_cnt(cnt2));

   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      load  = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      load  = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({x0, ready0, busy0, done0, cnt0} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: got x/rdy/busy/done/cnt=%b%b%b%b/%0d expected 0100/0",
                     i, x0, ready0, busy0, done0, cnt0);
         end
         tick();
      end
   endtask

   task automatic test_single_word();
      logic [7:0] w;
      w = 8'h55;
      do_reset();
      data_in = w;
      load    = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if ({x0, busy0, ready0} !== {w[8-i], 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL word55 cyc%0d: got x/busy/rdy=%b%b%b expected %b10",
                     i, x0, busy0, ready0, w[8-i]);
         end
         tick();
      end
      checks++;
      if ({done0, busy0, ready0, x0, cnt0} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd3}) begin
         errors++;
         $display("FAIL word55 cyc9: got done/busy/rdy/x/cnt=%b%b%b%b/%0d expected 1000/3",
                  done0, busy0, ready0, x0, cnt0);
      end
      tick();
      checks++;
      if ({ready0, done0} !== 2'b10) begin
         errors++;
         $display("FAIL word55 cyc10: got rdy/done=%b%b expected 10", ready0, done0);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w;
      w = 16'h0540;
      do_reset();
      data_in = 8'h05;
      load    = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         checks++;
         if ({x1, busy1, done1} !== {w[16-i], 1'b1, (i == 9)}) begin
            errors++;
            $display("FAIL b2b cyc%0d: got x/busy/done=%b%b%b expected %b1%b",
                     i, x1, busy1, done1, w[16-i], (i == 9));
         end
         if (i == 8) begin
            checks++;
            if (ready1 !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready cyc8: got %b expected 1", ready1);
            end
            data_in = 8'h40;
            load    = 1'b1;
         end
         tick();
         load = 1'b0;
      end
      checks++;
      if ({done1, busy1, cnt1} !== {1'b1, 1'b0, 8'd2}) begin
         errors++;
         $display("FAIL b2b cyc17: got done/busy/cnt=%b%b/%0d expected 10/2",
                  done1, busy1, cnt1);
      end
   endtask

   task automatic test_load_ignored();
      logic [7:0] w1;
      logic [7:0] w2;
      w1 = 8'hF0;
      w2 = 8'h0F;
      do_reset();
      data_in = w1;
      load    = 1'b1;
      tick();
      data_in = w2;
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if ({x0, busy0} !== {w1[8-i], 1'b1}) begin
            errors++;
            $display("FAIL ignore_load cyc%0d: got x/busy=%b%b expected %b1",
                     i, x0, busy0, w1[8-i]);
         end
         tick();
      end
      checks++;
      if ({x0, busy0, ready0} !== 3'b000) begin
         errors++;
         $display("FAIL ignore_load cyc9: got x/busy/rdy=%b%b%b expected 000", x0, busy0, ready0);
      end
      tick();
      checks++;
      if ({ready0, busy0} !== 2'b10) begin
         errors++;
         $display("FAIL ignore_load cyc10: got rdy/busy=%b%b expected 10", ready0, busy0);
      end
      tick();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({x0, busy0} !== {w2[7-i], 1'b1}) begin
            errors++;
            $display("FAIL second_word cyc%0d: got x/busy=%b%b expected %b1",
                     11 + i, x0, busy0, w2[7-i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      data_in = 8'hFF;
      load    = 1'b1;
      tick();
      load = 1'b0;
      tick();
      tick();
      checks++;
      if ({x0, busy0} !== 2'b11) begin
         errors++;
         $display("FAIL midreset cyc3: got x/busy=%b%b expected 11", x0, busy0);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({x0, busy0, ready0, done0, cnt0} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL midreset cyc4: got x/busy/rdy/done/cnt=%b%b%b%b/%0d expected 0010/0",
                  x0, busy0, ready0, done0, cnt0);
      end
      for (int i = 5; i <= 12; i++) begin
         tick();
         checks++;
         if ({x0, busy0, done0} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_discard cyc%0d: got x/busy/done=%b%b%b expected 000",
                     i, x0, busy0, done0);
         end
      end
   endtask

   task automatic test_cnt_wrap();
      do_reset();
      data_in = 8'h55;
      load    = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 1; i <= 8; i++) tick();
      checks++;
      if (cnt2 !== 2'd3) begin
         errors++;
         $display("FAIL wrap_first cyc9: got cnt=%0d expected 3", cnt2);
      end
      tick();
      checks++;
      if ({ready2, cnt2} !== {1'b1, 2'd3}) begin
         errors++;
         $display("FAIL wrap_gap cyc10: got rdy/cnt=%b/%0d expected 1/3", ready2, cnt2);
      end
      load = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if (busy2 !== 1'b1) begin
         errors++;
         $display("FAIL wrap_second_busy cyc11: got %b expected 1", busy2);
      end
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if ({done2, cnt2} !== {1'b1, 2'd2}) begin
         errors++;
         $display("FAIL wrap_second cyc19: got done/cnt=%b/%0d expected 1/2", done2, cnt2);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_load_ignored();
      test_reset_mid();
      test_cnt_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
